// File: rtl/acc_out_pkg.sv
// Shared types and the round/shift/saturate helper for the accumulator output stage.
// Defining ACC_OUT_RELU_EN clamps negative results to zero before saturation.
package acc_out_pkg;

    localparam int SUM_COUNT_W = 16;

    typedef struct packed {
        logic signed [31:0] value;
        logic               sat;
    } sat_res_t;

    function automatic sat_res_t sat_round(
        input logic signed [31:0] value,
        input int                 shift,
        input int                 width
    );
        sat_res_t           r;
        logic signed [31:0] v;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        v = value;
        if (shift > 0) begin
            v = v + (32'sd1 <<< (shift - 1));
        end
        v = v >>> shift;
`ifdef ACC_OUT_RELU_EN
        if (v < 0) begin
            v = '0;
        end
`endif
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        r.value = v;
        r.sat   = 1'b0;
        if (v > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (v < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/accumulator_output_stage_delay.sv
// Fixed-depth single-bit delay line; DEPTH=0 degenerates to a wire.
// Used to track new_sum/flush through the accumulator tree.
module pulse_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else if (DEPTH == 1) begin : g_one
            logic sr;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= 1'b0;
                end else begin
                    sr <= d;
                end
            end
            assign q = sr;
        end else begin : g_many
            logic [DEPTH-1:0] sr;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[DEPTH-2:0], d};
                end
            end
            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/accumulator_output_stage.sv
// Captures completed accumulator sums, applies bias/round/shift/saturate and
// hands results out over valid/ready. Optional ACC_OUT_RELU_EN clamps negatives.
module accumulator_output_stage
    import acc_out_pkg::*;
#(
    parameter int OUT_BITWIDTH = 10,
    parameter int LOG2_NO_IN   = 1,
    parameter int RES_BITWIDTH = 8,
    parameter int SHIFT        = 2,
    parameter int BIAS         = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           new_sum,
    input  logic                           flush,
    input  logic signed [OUT_BITWIDTH:0]   acc_in,
    output logic signed [RES_BITWIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           sat_flag,
    output logic                           overrun,
    output logic [SUM_COUNT_W-1:0]         sum_count
);

    localparam int S1W = OUT_BITWIDTH + 2;

    logic                  ns_d;
    logic                  fl_d;
    logic                  primed;
    logic                  capture;
    logic                  valid1;
    logic signed [S1W-1:0] sum1;
    sat_res_t              res;
    logic                  accept;
    logic                  blocked;
    logic                  unused_hi;

    pulse_delay_line #(.DEPTH(LOG2_NO_IN)) u_ns_dl (
        .clk (clk),
        .rst (rst),
        .d   (new_sum),
        .q   (ns_d)
    );

    pulse_delay_line #(.DEPTH(LOG2_NO_IN)) u_fl_dl (
        .clk (clk),
        .rst (rst),
        .d   (flush),
        .q   (fl_d)
    );

    // acc_in still holds the previous completed sum when the delayed pulse arrives
    assign capture = (ns_d || fl_d) && primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed <= 1'b0;
        end else if (ns_d) begin
            primed <= 1'b1;
        end else if (fl_d) begin
            primed <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1 <= 1'b0;
            sum1   <= '0;
        end else begin
            valid1 <= capture;
            if (capture) begin
                sum1 <= {acc_in[OUT_BITWIDTH], acc_in} + S1W'(BIAS);
            end
        end
    end

    assign res       = sat_round(32'(sum1), SHIFT, RES_BITWIDTH);
    assign unused_hi = ^res.value[31:RES_BITWIDTH];

    assign accept  = out_valid && out_ready;
    assign blocked = out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
            overrun   <= 1'b0;
            sum_count <= '0;
        end else begin
            if (valid1 && !blocked) begin
                out_valid <= 1'b1;
                out_data  <= res.value[RES_BITWIDTH-1:0];
                if (res.sat) begin
                    sat_flag <= 1'b1;
                end
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            // holding register full: keep the old result, drop the new one
            if (valid1 && blocked) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                sum_count <= sum_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_output_stage.sv
// Self-checking bench for accumulator_output_stage: vector table plus
// hand-written sequences, with a scoreboard queue checked on acceptance.
module tb_accumulator_output_stage;

    localparam int OW   = 10;
    localparam int RW   = 8;
    localparam int SH   = 2;
    localparam int BIAS = 0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 new_sum;
    logic                 flush;
    logic signed [OW:0]   acc_in;
    logic signed [RW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sat_flag;
    logic                 overrun;
    logic [15:0]          sum_count;

    logic                 z_ns;
    logic                 z_fl;
    logic signed [OW:0]   z_acc;
    logic signed [RW-1:0] z_data;
    logic                 z_valid;
    logic                 z_rdy;
    logic                 z_sat;
    logic                 z_ovr;
    logic [15:0]          z_cnt;

    always #5 clk = ~clk;

    accumulator_output_stage #(
        .OUT_BITWIDTH(OW), .LOG2_NO_IN(1), .RES_BITWIDTH(RW),
        .SHIFT(SH), .BIAS(BIAS)
    ) dut (
        .clk(clk), .rst(rst), .new_sum(new_sum), .flush(flush),
        .acc_in(acc_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sat_flag(sat_flag), .overrun(overrun),
        .sum_count(sum_count)
    );

    accumulator_output_stage #(
        .OUT_BITWIDTH(OW), .LOG2_NO_IN(0), .RES_BITWIDTH(RW),
        .SHIFT(SH), .BIAS(BIAS)
    ) dut0 (
        .clk(clk), .rst(rst), .new_sum(z_ns), .flush(z_fl),
        .acc_in(z_acc), .out_data(z_data), .out_valid(z_valid),
        .out_ready(z_rdy), .sat_flag(z_sat), .overrun(z_ovr),
        .sum_count(z_cnt)
    );

    typedef struct {
        int d;
        bit sat;
    } exp_t;

    typedef struct {
        int acc;
        int d;
        bit sat;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t q0[$];
    bit   exp_sat;
    int   accepted;
    bit   primed_m;
    int   cyc_cnt  = 0;
    int   z_times[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // floor division with explicit negative correction, then clamp
    function automatic exp_t model(input int v);
        exp_t e;
        int   n;
        int   d;
        int   r;
        n = v + BIAS + ((SH > 0) ? (1 << (SH - 1)) : 0);
        d = 1 << SH;
        r = n / d;
        if (n < 0 && (n % d) != 0) r = r - 1;
`ifdef ACC_OUT_RELU_EN
        if (r < 0) r = 0;
`endif
        e.sat = 1'b0;
        e.d   = r;
        if (r > (1 << (RW - 1)) - 1) begin
            e.d   = (1 << (RW - 1)) - 1;
            e.sat = 1'b1;
        end else if (r < -(1 << (RW - 1))) begin
            e.d   = -(1 << (RW - 1));
            e.sat = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0d expected none", out_data);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                exp_sat = exp_sat | e.sat;
                chk("sat_flag", sat_flag, exp_sat);
                accepted++;
            end
        end
        if (!rst && z_valid && z_rdy) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL z_unexpected: got %0d expected none", z_data);
            end else begin
                e = q0.pop_front();
                chk("z_out_data", z_data, e.d);
                z_times.push_back(cyc_cnt);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int acc, input bit fl, input bit push);
        acc_in  = acc[OW:0];
        new_sum = !fl;
        flush   = fl;
        if (primed_m && push) q.push_back(model(acc));
        primed_m = !fl;
        cyc(1);
        new_sum = 1'b0;
        flush   = 1'b0;
        cyc(2);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || q0.size() > 0) && n < 40) begin
            cyc(1);
            n++;
        end
        checks++;
        if (q.size() > 0 || q0.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q.size() + q0.size());
        end
        cyc(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        exp_sat  = 1'b0;
        accepted = 0;
        primed_m = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    vec_t vt[12];

    initial begin
        int   a[12];
        exp_t e;
        a = '{301, 1000, -7, -1024, 2, 1, -2, -3, 509, 510, -514, -515};
        foreach (a[i]) begin
            e = model(a[i]);
            vt[i].acc = a[i];
            vt[i].d   = e.d;
            vt[i].sat = e.sat;
        end

        rst = 1'b1; new_sum = 1'b0; flush = 1'b0; acc_in = '0; out_ready = 1'b1;
        z_ns = 1'b0; z_fl = 1'b0; z_acc = '0; z_rdy = 1'b1;
        exp_sat = 1'b0; accepted = 0; primed_m = 1'b0;
        cyc(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sum_count", sum_count, 0);
        rst = 1'b0;
        cyc(2);

        // first new_sum only primes; exact latency on the second
        send(0, 1'b0, 1'b1);
        cyc(2);
        chk("prime_no_output", out_valid, 0);
        acc_in  = 11'sd301;
        new_sum = 1'b1;
        q.push_back(model(301));
        cyc(1);
        new_sum = 1'b0;
        cyc(1);
        chk("latency_early", out_valid, 0);
        cyc(1);
        chk("latency_valid", out_valid, 1);
        drain();
        chk("first_sum_count", sum_count, 1);
        chk("first_sat_flag", sat_flag, 0);

        foreach (vt[i]) begin
            chk("table_model", model(vt[i].acc).d, vt[i].d);
            send(vt[i].acc, 1'b0, 1'b1);
        end
        drain();
        chk("table_sum_count", sum_count, accepted);
        chk("table_sat_sticky", sat_flag, exp_sat);

        // reset one cycle after a capture edge discards the in-flight sum
        acc_in  = 11'sd100;
        new_sum = 1'b1;
        cyc(1);
        new_sum = 1'b0;
        cyc(1);
        rst = 1'b1;
        q.delete();
        exp_sat = 1'b0; accepted = 0; primed_m = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_count", sum_count, 0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        chk("post_rst_valid", out_valid, 0);
        send(55, 1'b0, 1'b1);
        cyc(4);
        chk("post_rst_prime", out_valid, 0);

        // flush emits the primed sum and un-primes
        send(40, 1'b1, 1'b1);
        drain();
        chk("flush_count", sum_count, 1);
        send(77, 1'b0, 1'b1);
        cyc(4);
        chk("after_flush_silent", out_valid, 0);
        send(8, 1'b0, 1'b1);
        drain();
        chk("after_flush_count", sum_count, 2);

        // holding register full: second result dropped
        do_reset();
        send(0, 1'b0, 1'b1);
        out_ready = 1'b0;
        send(50, 1'b0, 1'b1);
        cyc(1);
        send(60, 1'b0, 1'b0);
        cyc(3);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, 13);
        chk("overrun", overrun, 1);
        chk("hold_count", sum_count, 0);
        out_ready = 1'b1;
        drain();
        chk("ovr_sum_count", sum_count, 1);
        chk("ovr_valid_drop", out_valid, 0);

        // zero-depth instance: captures on consecutive cycles
        z_ns  = 1'b1;
        z_acc = '0;
        cyc(1);
        z_acc = 11'sd4;  q0.push_back(model(4));  cyc(1);
        z_acc = 11'sd8;  q0.push_back(model(8));  cyc(1);
        z_acc = 11'sd12; q0.push_back(model(12)); cyc(1);
        z_acc = 11'sd16; z_fl = 1'b1; q0.push_back(model(16)); cyc(1);
        z_ns = 1'b0; z_fl = 1'b0;
        cyc(2);
        z_acc = 11'sd20; z_ns = 1'b1; q0.push_back(model(20)); cyc(1);
        z_ns = 1'b0;
        drain();
        chk("z_count", z_cnt, 5);
        if (z_times.size() >= 3) begin
            chk("z_back2back_1", z_times[1] - z_times[0], 1);
            chk("z_back2back_2", z_times[2] - z_times[1], 1);
        end else begin
            checks++;
            failures++;
            $display("FAIL z_times: got %0d results expected 3", z_times.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/accumulator_output_stage.md
Name: accumulator_output_stage

Overview:
Downstream consumer of the pipelined adder-tree accumulator in the CNN datapath. Tracks the accumulator's new_sum pipeline to detect when a complete sum is present on the accumulator output, then captures it. Each captured sum gets a bias add, round-half-up arithmetic right shift and saturation. The result is presented to the next layer over a valid/ready interface with a one-entry holding register.

Parameters:
OUT_BITWIDTH, 10, accumulator output is OUT_BITWIDTH+1 bits signed (matches accumulator parameter)
LOG2_NO_IN, 1, accumulator tree depth; the accumulator's new_sum reaches its final register after LOG2_NO_IN cycles
RES_BITWIDTH, 8, signed result width
SHIFT, 2, arithmetic right-shift amount (0 allowed; no rounding when 0)
BIAS, 0, signed bias; must fit in OUT_BITWIDTH+1 bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
new_sum  in  1  same pulse driven into the accumulator's new_sum
flush  in  1  emit the in-progress sum without starting a new one
acc_in  in  OUT_BITWIDTH+1  signed accumulator data_out
out_data  out  RES_BITWIDTH  signed result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts when out_valid && out_ready
sat_flag  out  1  sticky: some result was saturated
overrun  out  1  sticky: a result was dropped because the holding register was full
sum_count  out  16  number of results accepted by consumer, wraps at 2^16

Behaviour:
- Reset (async, rst=1): delay lines cleared, primed=0, stage-1 valid=0, out_valid=0, out_data=0, sat_flag=0, overrun=0, sum_count=0.
- Delay line: new_sum and flush are each delayed by exactly LOG2_NO_IN registers, giving ns_d and fl_d. When LOG2_NO_IN=0, ns_d=new_sum and fl_d=flush combinationally.
- Capture: the capture event is (ns_d || fl_d) && primed. On that edge acc_in still holds the completed previous sum. Register acc_in + BIAS at width OUT_BITWIDTH+2 into stage 1 and set valid1.
- primed:
  - set on any edge with ns_d=1;
  - cleared on an edge with fl_d=1 and ns_d=0;
  - when ns_d and fl_d are both 1, fl_d is ignored (ordinary new_sum).
- The first new_sum after reset or after a flush produces no output.
- Stage 2 (one cycle after stage 1):
  - add 2^(SHIFT-1) if SHIFT>0, then arithmetic shift right by SHIFT (floor after rounding offset);
  - saturate to [-2^(RES_BITWIDTH-1), 2^(RES_BITWIDTH-1)-1];
  - set sat_flag if clipped.
- Latency: out_valid rises 2 cycles after the capture edge.
- Handshake:
  - out_data is stable while out_valid && !out_ready;
  - out_valid drops the cycle after acceptance unless a new result loads on the same edge (back-to-back allowed);
  - sum_count increments per accepted result.
- Overrun: if stage 2 is about to load while out_valid && !out_ready, the new result is dropped, the held value is kept, and overrun is set.
- Timing note: sums are at least 1 cycle apart, so stage 1 never overruns. Captures on consecutive cycles are legal and must each produce a result.
- Reset mid-operation discards all in-flight captures; nothing is emitted for them.

Optional Feature:
ACC_OUT_RELU_EN: when defined, the stage-2 result is clamped to 0 if negative, applied after shift and before saturation. Negative-side clipping then never sets sat_flag. When undefined, signed results pass through unchanged.

Decomposition:
- Package acc_out_pkg holds:
  - function sat_round(value, shift, width) implementing round/shift/saturate plus a saturated indicator;
  - localparam SUM_COUNT_W=16.
- Sub-module pulse_delay_line (parameter DEPTH, async active-high reset, DEPTH=0 means a wire) is instantiated twice, for new_sum and flush.

Test Plan:
- Defaults, LOG2_NO_IN=1. new_sum at t0, acc_in=301 at t0+1, new_sum at t0+5, out_ready=1 -> exactly one result, out_data=75, 2 cycles after capture edge t0+6; sat_flag=0; sum_count=1.
- acc_in=1000 at capture -> out_data=127, sat_flag=1. Then acc_in=-7 -> out_data=-2 (out_data=0 with ACC_OUT_RELU_EN).
- flush at t0 after a primed sum of 40 -> out_data=10. A following new_sum emits nothing; the next new_sum emits again.
- out_ready=0; two sums 50 then 60 captured 4 cycles apart -> out_data stays 13, overrun=1; on out_ready=1 the 13 is accepted and sum_count=1.
- rst asserted 1 cycle after a capture edge -> no out_valid ever; all outputs 0 immediately. The first post-reset new_sum emits nothing.
- LOG2_NO_IN=0, new_sum every cycle with acc_in 4, 8, 12 -> results 1, 2, 3 on consecutive cycles; new_sum together with flush behaves as new_sum only.
